// File: rtl/si_tx_arbiter.sv
// si_tx_arbiter: round-robin packet-locked arbiter sharing the FT245 SI tx channel; ports clk, rst (sync active-low), req_rdy/req_data/req_last/req_ack per requester, tx_data_si/tx_rdy_si/tx_ack_si to wrapper, grant, busy, err_timeout; option SI_ARB_TIMEOUT_EN
module si_tx_arbiter #(
  parameter int N_REQ = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_rdy,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         tx_data_si,
  output logic               tx_rdy_si,
  input  logic               tx_ack_si,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               err_timeout
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, gidx, gidx_n, widx, nxt;
  logic [IW:0] sum;
  logic win, last, last_n, busy_n, tmo;
  logic [7:0] data_n;
  logic [N_REQ-1:0] grant_n, ack_n;
`ifdef SI_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = state == SEND && !tx_ack_si && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    cnt <= (!rst || state != SEND) ? '0 : cnt + 16'd1;
    err_timeout <= !rst ? 1'b0 : err_timeout | tmo;
  end
`else
  assign tmo = 1'b0;
  assign err_timeout = 1'b0;
`endif
  assign tx_rdy_si = state == SEND;
  assign nxt = gidx == IW'(N_REQ - 1) ? '0 : gidx + IW'(1);
  always_comb begin
    win = 1'b0;
    widx = '0;
    sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      sum = sum >= (IW+1)'(N_REQ) ? sum - (IW+1)'(N_REQ) : sum;
      if (req_rdy[sum[IW-1:0]] && !req_ack[sum[IW-1:0]]) begin
        win = 1'b1;
        widx = sum[IW-1:0];
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gidx_n = gidx;
    last_n = last;
    data_n = tx_data_si;
    grant_n = grant;
    busy_n = busy;
    ack_n = '0;
    case (state)
      IDLE: if (win) begin
        state_n = SEND;
        gidx_n = widx;
        data_n = req_data[8*widx +: 8];
        last_n = req_last[widx];
        grant_n = N_REQ'(1) << widx;
        busy_n = 1'b1;
      end
      SEND: if (tx_ack_si) begin
        state_n = ACK;
        ack_n = grant;
      end else if (tmo) begin
        state_n = IDLE;
        ack_n = grant;
        ptr_n = nxt;
        grant_n = '0;
        busy_n = 1'b0;
      end
      ACK: if (last) begin
        state_n = IDLE;
        ptr_n = nxt;
        grant_n = '0;
        busy_n = 1'b0;
      end else state_n = HOLD;
      HOLD: if (req_rdy[gidx]) begin
        state_n = SEND;
        data_n = req_data[8*gidx +: 8];
        last_n = req_last[gidx];
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      last <= 1'b0;
      tx_data_si <= '0;
      grant <= '0;
      busy <= 1'b0;
      req_ack <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gidx <= gidx_n;
      last <= last_n;
      tx_data_si <= data_n;
      grant <= grant_n;
      busy <= busy_n;
      req_ack <= ack_n;
    end
  end
endmodule

// File: tb/tb_si_tx_arbiter.sv
// tb_si_tx_arbiter: scoreboard bench for si_tx_arbiter against a packet-level round-robin model
module tb_si_tx_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b0, tx_ack_si = 1'b0;
  logic [N-1:0] req_rdy = '0, req_last = '0, req_ack, grant;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data_si;
  logic tx_rdy_si, busy, err_timeout;
  typedef struct {logic [7:0] d; logic l; int gap;} item_t;
  typedef struct {logic [7:0] d; int who;} exp_t;
  item_t rq[N][$];
  exp_t eq[$];
  int checks = 0, errors = 0;
  int gapc[N];
  bit loaded[N];
  logic [N-1:0] ack_prev = '0, ack_pend = '0;
  int wcnt = 0, ack_fix = -1, mptr = 0, c, n;
  bit ack_en = 1'b1, stray_en = 1'b0, mon_en = 1'b0;
  always #5 clk = ~clk;
  si_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_rdy(req_rdy), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input int r, input logic [7:0] d, input logic l, input int gap);
    item_t it;
    it.d = d;
    it.l = l;
    it.gap = gap;
    rq[r].push_back(it);
  endtask
  function automatic int delay();
    return ack_fix >= 0 ? ack_fix : int'($urandom_range(0, 3));
  endfunction
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model();
    int pos[N];
    int left, r;
    bit done;
    exp_t e;
    left = 0;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0;
      left += rq[i].size();
    end
    while (left > 0) begin
      r = mptr;
      while (pos[r] >= rq[r].size()) r = (r + 1) % N;
      done = 1'b0;
      while (!done) begin
        e.d = rq[r][pos[r]].d;
        e.who = r;
        done = rq[r][pos[r]].l;
        eq.push_back(e);
        pos[r]++;
        left--;
      end
      mptr = (r + 1) % N;
    end
    wcnt = delay();
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_prev[i] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        loaded[i] = 1'b0;
      end
      if (rq[i].size() > 0 && !loaded[i]) begin
        gapc[i] = rq[i][0].gap;
        loaded[i] = 1'b1;
      end
      if (rq[i].size() == 0) req_rdy[i] = 1'b0;
      else if (gapc[i] > 0) begin
        req_rdy[i] = 1'b0;
        gapc[i]--;
      end else begin
        req_rdy[i] = 1'b1;
        req_data[8*i +: 8] = rq[i][0].d;
        req_last[i] = rq[i][0].l;
      end
    end
    ack_prev = req_ack;
    if (tx_ack_si) tx_ack_si = 1'b0;
    else if (tx_rdy_si && ack_en) begin
      if (wcnt == 0) begin
        tx_ack_si = 1'b1;
        wcnt = delay();
      end else wcnt--;
    end else if (!tx_rdy_si && stray_en && $urandom_range(0, 15) == 0) tx_ack_si = 1'b1;
  endtask
  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((eq.size() > 0 || pending()) && cyc < 2000) begin
      step();
      cyc++;
    end
    check({name, " outstanding bytes"}, eq.size(), 0);
    step();
    check({name, " idle outputs"}, {busy, tx_rdy_si, err_timeout, grant}, 0);
  endtask
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    check("req_ack pulse", req_ack, ack_pend);
    if (tx_rdy_si && tx_ack_si) begin
      if (eq.size() == 0) check("unexpected byte", 1, 0);
      else begin
        e = eq.pop_front();
        check("tx_data_si", tx_data_si, e.d);
        check("grant owner", grant, N'(1) << e.who);
      end
      ack_pend = grant;
    end else ack_pend = '0;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      gapc[i] = 0;
      loaded[i] = 1'b0;
    end
    ack_fix = 2;
    add(0, 8'hA1, 1'b0, 0);
    add(0, 8'hA2, 1'b0, 0);
    add(0, 8'hA3, 1'b1, 0);
    add(1, 8'hB1, 1'b1, 0);
    model();
    repeat (3) begin
      step();
      check("reset outputs", {req_ack, tx_data_si, tx_rdy_si, grant, busy, err_timeout}, 0);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    step();
    check("grant after reset", grant, 1);
    drain("reset");
    add(0, 8'hC1, 1'b0, 0);
    add(0, 8'hC2, 1'b0, 0);
    add(0, 8'hC3, 1'b1, 0);
    model();
    drain("single");
    add(0, 8'h11, 1'b0, 0);
    add(0, 8'h12, 1'b1, 0);
    add(1, 8'h21, 1'b0, 0);
    add(1, 8'h22, 1'b1, 0);
    model();
    drain("contention");
    for (int i = 0; i < 4; i++) add(0, 8'(8'h50 + i), 1'b1, 0);
    add(1, 8'h61, 1'b1, 0);
    model();
    drain("fairness");
    add(1, 8'h31, 1'b0, 0);
    add(1, 8'h32, 1'b1, 20);
    add(0, 8'h41, 1'b1, 0);
    model();
    drain("hold stall");
    ack_fix = -1;
    stray_en = 1'b1;
    repeat (30) begin
      for (int r = 0; r < N; r++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            add(r, 8'($urandom), b == len - 1,
                (b != 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0);
        end
      end
      model();
      drain("random");
    end
    mon_en = 1'b0;
    stray_en = 1'b0;
    ack_en = 1'b0;
    add(0, 8'h5A, 1'b1, 0);
    n = 0;
    while (!tx_rdy_si && n < 10) begin
      step();
      n++;
    end
    check("tx_rdy_si rises", tx_rdy_si, 1);
    c = 1;
`ifdef SI_ARB_TIMEOUT_EN
    while (tx_rdy_si && c < 200) begin
      step();
      if (tx_rdy_si) c++;
    end
    check("send cycles before timeout", c, 16);
    check("timeout err/busy/grant/ack", {err_timeout, busy, grant, req_ack}, {1'b1, 1'b0, N'(0), N'(1)});
    step();
    check("after timeout", {req_ack, grant, tx_rdy_si, err_timeout}, {N'(0), N'(0), 1'b0, 1'b1});
`else
    while (tx_rdy_si && c < 100) begin
      step();
      if (tx_rdy_si) c++;
    end
    check("send held without timeout", c, 100);
    check("tx_rdy_si still high", tx_rdy_si, 1);
    check("err_timeout tied low", err_timeout, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
